// File: rtl/crc_pkg.sv
// crc_pkg: shared types and helpers for the receive-side CRC checker.
package crc_pkg;

   // The registered result record is sized for 32-bit CRCs.
   localparam int CRC_W = 32;

   typedef struct packed {
      logic             ok;
      logic [CRC_W-1:0] calc;
      logic [CRC_W-1:0] rx;
   } crc_result_t;

   // FIFO pointer width: the extra MSB tells a full FIFO from an empty one.
   function automatic int ptr_w(input int depth);
      return $clog2(depth) + 1;
   endfunction

endpackage

// File: rtl/crc_check_if.sv
// crc_check_if: flit stream, received-CRC sideband and check results.
interface crc_check_if #(
   parameter int DWIDTH    = 512,
   parameter int CRC_WIDTH = 32,
   parameter int CNT_W     = 32
);
   logic [DWIDTH-1:0]    din;
   logic                 flitEn;
   logic                 dlast;
   logic [CRC_WIDTH-1:0] crc_in;
   logic                 chk_vld;
   logic                 chk_ok;
   logic [CRC_WIDTH-1:0] crc_calc;
   logic [CRC_WIDTH-1:0] crc_rx;
   logic [CNT_W-1:0]     good_cnt;
   logic [CNT_W-1:0]     bad_cnt;
   logic                 ovf_err;
   logic                 unf_err;

   modport master (
      output din, flitEn, dlast, crc_in,
      input  chk_vld, chk_ok, crc_calc, crc_rx, good_cnt, bad_cnt, ovf_err, unf_err
   );

   modport slave (
      input  din, flitEn, dlast, crc_in,
      output chk_vld, chk_ok, crc_calc, crc_rx, good_cnt, bad_cnt, ovf_err, unf_err
   );
endinterface

// File: rtl/crc_gen.sv
// crc_gen: streaming CRC over DWIDTH-bit flits. Bytes are consumed from the
// top of the flit downwards; the final CRC appears PIPE_LVL cycles after the
// last flit of a frame.
module crc_gen #(
   parameter int                   DWIDTH    = 512,
   parameter int                   CRC_WIDTH = 32,
   parameter int                   PIPE_LVL  = 2,
   parameter logic [CRC_WIDTH-1:0] CRC_POLY  = 32'h04C1_1DB7,
   parameter logic [CRC_WIDTH-1:0] INIT      = 32'hFFFF_FFFF,
   parameter logic [CRC_WIDTH-1:0] XOR_OUT   = 32'hFFFF_FFFF,
   parameter bit                   REFIN     = 1'b1,
   parameter bit                   REFOUT    = 1'b1
) (
   input  logic                 clk,
   input  logic                 rst,
   input  logic [DWIDTH-1:0]    din,
   input  logic                 flitEn,
   input  logic                 dlast,
   output logic [CRC_WIDTH-1:0] crc_out,
   output logic                 crc_out_vld
);

   logic [CRC_WIDTH-1:0]                crc_q;
   logic [CRC_WIDTH-1:0]                crc_d;
   logic [PIPE_LVL-1:0][CRC_WIDTH-1:0]  pipe_q;
   logic [PIPE_LVL-1:0]                 vld_q;

   // One flit through the serial LFSR; REFIN feeds each byte LSB first.
   function automatic logic [CRC_WIDTH-1:0] crc_step(input logic [CRC_WIDTH-1:0] c_in,
                                                     input logic [DWIDTH-1:0]    d);
      logic [CRC_WIDTH-1:0] c;
      logic                 fb;
      c = c_in;
      for (int i = DWIDTH/8 - 1; i >= 0; i--) begin
         for (int j = 0; j < 8; j++) begin
            fb = c[CRC_WIDTH-1] ^ (REFIN ? d[8*i + j] : d[8*i + 7 - j]);
            c  = {c[CRC_WIDTH-2:0], 1'b0} ^ (fb ? CRC_POLY : '0);
         end
      end
      return c;
   endfunction

   // Output reflection and final XOR.
   function automatic logic [CRC_WIDTH-1:0] finalize(input logic [CRC_WIDTH-1:0] c);
      logic [CRC_WIDTH-1:0] r;
      for (int k = 0; k < CRC_WIDTH; k++) r[k] = REFOUT ? c[CRC_WIDTH-1-k] : c[k];
      return r ^ XOR_OUT;
   endfunction

   // Remainder after absorbing the current flit.
   always_comb begin
      crc_d = crc_step(crc_q, din);
   end

   // Running remainder, restarted from INIT after each last flit.
   always_ff @(posedge clk) begin
      if (rst)         crc_q <= INIT;
      else if (flitEn) crc_q <= dlast ? INIT : crc_d;
   end

   // Result-valid delay line.
   always_ff @(posedge clk) begin
      if (rst) begin
         vld_q <= '0;
      end else begin
         vld_q[0] <= flitEn && dlast;
         for (int k = 1; k < PIPE_LVL; k++) vld_q[k] <= vld_q[k-1];
      end
   end

   // Result data delay line, travelling alongside vld_q.
   always_ff @(posedge clk) begin
      if (flitEn && dlast) pipe_q[0] <= finalize(crc_d);
      for (int k = 1; k < PIPE_LVL; k++) pipe_q[k] <= pipe_q[k-1];
   end

   assign crc_out     = pipe_q[PIPE_LVL-1];
   assign crc_out_vld = vld_q[PIPE_LVL-1];

endmodule

// File: rtl/crc_check.sv
// crc_check: receive-side CRC checker. Received CRCs queue in an in-order
// FIFO until crc_gen delivers the computed value for the same frame; the
// pair is compared, reported and counted.
module crc_check
   import crc_pkg::*;
#(
   parameter int                   DWIDTH    = 512,
   parameter int                   CRC_WIDTH = 32,
   parameter int                   PIPE_LVL  = 2,
   parameter logic [CRC_WIDTH-1:0] CRC_POLY  = 32'h04C1_1DB7,
   parameter logic [CRC_WIDTH-1:0] INIT      = 32'hFFFF_FFFF,
   parameter logic [CRC_WIDTH-1:0] XOR_OUT   = 32'hFFFF_FFFF,
   parameter bit                   REFIN     = 1'b1,
   parameter bit                   REFOUT    = 1'b1,
   parameter int                   DEPTH     = 8,
   parameter int                   CNT_W     = 32
) (
   input  logic      clk,
   input  logic      rst_n,
   crc_check_if.slave bus
);

   localparam int PW = ptr_w(DEPTH);
   localparam int AW = PW - 1;

   logic [CRC_WIDTH-1:0] gen_crc;
   logic                 gen_vld;

   logic [CRC_WIDTH-1:0] mem_q [DEPTH];
   logic [PW-1:0]        wr_ptr_q, wr_ptr_d, rd_ptr_q, rd_ptr_d;
   logic                 ovf_q, ovf_d, unf_q, unf_d;
   logic                 chk_vld_q, chk_vld_d;
   crc_result_t          res_q, res_d;
   logic [CNT_W-1:0]     good_q, good_d, bad_q, bad_d;

   logic                 push, pop, empty, full, bypass, do_pop, do_write;
   logic [CRC_WIDTH-1:0] cmp_rx;

   crc_gen #(
      .DWIDTH   (DWIDTH),
      .CRC_WIDTH(CRC_WIDTH),
      .PIPE_LVL (PIPE_LVL),
      .CRC_POLY (CRC_POLY),
      .INIT     (INIT),
      .XOR_OUT  (XOR_OUT),
      .REFIN    (REFIN),
      .REFOUT   (REFOUT)
   ) u_crc_gen (
      .clk        (clk),
      .rst        (!rst_n),
      .din        (bus.din),
      .flitEn     (bus.flitEn),
      .dlast      (bus.dlast),
      .crc_out    (gen_crc),
      .crc_out_vld(gen_vld)
   );

   assign push     = bus.flitEn && bus.dlast;
   assign pop      = gen_vld;
   assign empty    = (wr_ptr_q == rd_ptr_q);
   assign full     = (wr_ptr_q[AW] != rd_ptr_q[AW]) && (wr_ptr_q[AW-1:0] == rd_ptr_q[AW-1:0]);
   // An empty FIFO with a simultaneous push hands crc_in straight to the compare.
   assign bypass   = pop && empty && push;
   assign do_pop   = pop && !empty;
   assign do_write = push && !bypass && (!full || do_pop);
   assign cmp_rx   = bypass ? bus.crc_in : mem_q[rd_ptr_q[AW-1:0]];

   // Next state: FIFO pointers, sticky errors, compare result, counters.
   always_comb begin
      wr_ptr_d  = wr_ptr_q;
      rd_ptr_d  = rd_ptr_q;
      ovf_d     = ovf_q;
      unf_d     = unf_q;
      chk_vld_d = 1'b0;
      res_d     = res_q;
      good_d    = good_q;
      bad_d     = bad_q;
      if (do_write) wr_ptr_d = wr_ptr_q + PW'(1);
      if (do_pop)   rd_ptr_d = rd_ptr_q + PW'(1);
      if (push && full && !do_pop) ovf_d = 1'b1;
      if (pop && empty && !push)   unf_d = 1'b1;
      if (do_pop || bypass) begin
         chk_vld_d  = 1'b1;
         res_d.ok   = (gen_crc == cmp_rx);
         res_d.calc = CRC_W'(gen_crc);
         res_d.rx   = CRC_W'(cmp_rx);
         if (gen_crc == cmp_rx) begin
            if (good_q != {CNT_W{1'b1}}) good_d = good_q + CNT_W'(1);
         end else begin
            if (bad_q != {CNT_W{1'b1}}) bad_d = bad_q + CNT_W'(1);
         end
      end
   end

   // Control and result registers.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         wr_ptr_q  <= '0;
         rd_ptr_q  <= '0;
         ovf_q     <= 1'b0;
         unf_q     <= 1'b0;
         chk_vld_q <= 1'b0;
         res_q     <= '0;
         good_q    <= '0;
         bad_q     <= '0;
      end else begin
         wr_ptr_q  <= wr_ptr_d;
         rd_ptr_q  <= rd_ptr_d;
         ovf_q     <= ovf_d;
         unf_q     <= unf_d;
         chk_vld_q <= chk_vld_d;
         res_q     <= res_d;
         good_q    <= good_d;
         bad_q     <= bad_d;
      end
   end

   // FIFO storage; contents are only meaningful between the pointers.
   always_ff @(posedge clk) begin
      if (do_write) mem_q[wr_ptr_q[AW-1:0]] <= bus.crc_in;
   end

   assign bus.chk_vld  = chk_vld_q;
   assign bus.chk_ok   = res_q.ok;
   assign bus.crc_calc = CRC_WIDTH'(res_q.calc);
   assign bus.crc_rx   = CRC_WIDTH'(res_q.rx);
   assign bus.good_cnt = good_q;
   assign bus.bad_cnt  = bad_q;
   assign bus.ovf_err  = ovf_q;
   assign bus.unf_err  = unf_q;

endmodule

// File: tb/tb_crc_check.sv
// tb_crc_check: randomized frames against a byte-wise reflected CRC-32 model.
module tb_crc_check;

   localparam int DW     = 512;
   localparam int PIPE_A = 2;

   logic          clk = 1'b0;
   logic          rst_n;
   logic [DW-1:0] din;
   logic          flitEn, dlast;
   logic [31:0]   crc_in;
   int            sel;
   int            cyc = 0;
   int            n_chk = 0;
   int            n_pass = 0;
   int            pulses_a = 0;

   typedef struct {
      logic        ok;
      logic [31:0] calc;
      logic [31:0] rx;
      int          cyc;
   } exp_t;
   exp_t exp_q[$];

   always #5 clk = ~clk;
   always @(posedge clk) cyc <= cyc + 1;

   crc_check_if #(.DWIDTH(DW), .CRC_WIDTH(32), .CNT_W(32)) ifa ();
   crc_check_if #(.DWIDTH(DW), .CRC_WIDTH(32), .CNT_W(32)) ifb ();
   crc_check_if #(.DWIDTH(DW), .CRC_WIDTH(32), .CNT_W(4))  ifc ();

   assign ifa.din = din;  assign ifa.dlast = dlast;  assign ifa.crc_in = crc_in;
   assign ifb.din = din;  assign ifb.dlast = dlast;  assign ifb.crc_in = crc_in;
   assign ifc.din = din;  assign ifc.dlast = dlast;  assign ifc.crc_in = crc_in;
   assign ifa.flitEn = flitEn && (sel == 0);
   assign ifb.flitEn = flitEn && (sel == 1);
   assign ifc.flitEn = flitEn && (sel == 2);

   crc_check #(.DWIDTH(DW), .PIPE_LVL(PIPE_A), .DEPTH(8), .CNT_W(32))
      dut_a (.clk(clk), .rst_n(rst_n), .bus(ifa));
   crc_check #(.DWIDTH(DW), .PIPE_LVL(4), .DEPTH(2), .CNT_W(32))
      dut_b (.clk(clk), .rst_n(rst_n), .bus(ifb));
   crc_check #(.DWIDTH(DW), .PIPE_LVL(2), .DEPTH(8), .CNT_W(4))
      dut_c (.clk(clk), .rst_n(rst_n), .bus(ifc));

   task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
      n_chk++;
      if (got !== exp) $display("FAIL %s: got %0h required %0h", tag, got, exp);
      else n_pass++;
   endtask

   // Standard reflected CRC-32, one byte at a time, first byte = top of flit.
   function automatic logic [31:0] crc32_ref(input logic [DW-1:0] flits[$]);
      logic [31:0] c;
      logic [7:0]  b;
      c = 32'hFFFF_FFFF;
      foreach (flits[f]) begin
         for (int k = DW/8 - 1; k >= 0; k--) begin
            b = flits[f][8*k +: 8];
            c = c ^ {24'h0, b};
            repeat (8) c = c[0] ? ((c >> 1) ^ 32'hEDB8_8320) : (c >> 1);
         end
      end
      return ~c;
   endfunction

   function automatic logic [DW-1:0] rand_flit();
      logic [DW-1:0] f;
      for (int w = 0; w < DW/32; w++) f[32*w +: 32] = $urandom;
      return f;
   endfunction

   task automatic drive_flit(input int s, input logic [DW-1:0] d, input logic last,
                             input logic [31:0] c);
      sel = s; din = d; flitEn = 1'b1; dlast = last; crc_in = c;
      @(posedge clk); #1;
   endtask

   task automatic idle(input int n);
      flitEn = 1'b0; dlast = 1'b0;
      repeat (n) begin @(posedge clk); #1; end
   endtask

   // Sends a frame with crc_in = reference ^ flip; frames to dut_a are scoreboarded.
   task automatic send_frame(input int s, input logic [DW-1:0] flits[$], input logic [31:0] flip);
      logic [31:0] ref_crc;
      exp_t        e;
      ref_crc = crc32_ref(flits);
      for (int i = 0; i < flits.size(); i++) begin
         if (i == flits.size() - 1 && s == 0) begin
            e.ok = (flip == 32'h0); e.calc = ref_crc; e.rx = ref_crc ^ flip;
            e.cyc = cyc + PIPE_A + 1;
            exp_q.push_back(e);
         end
         drive_flit(s, flits[i], i == flits.size() - 1, ref_crc ^ flip);
      end
   endtask

   task automatic drain();
      int t;
      t = 0;
      flitEn = 1'b0; dlast = 1'b0;
      while (exp_q.size() != 0 && t < 50) begin @(posedge clk); #1; t++; end
      chk("drain", exp_q.size(), 0);
      idle(2);
   endtask

   task automatic check_reset_vals(input string tag);
      chk({tag, "_chk_vld"},  ifa.chk_vld,  0);
      chk({tag, "_chk_ok"},   ifa.chk_ok,   0);
      chk({tag, "_crc_calc"}, ifa.crc_calc, 0);
      chk({tag, "_crc_rx"},   ifa.crc_rx,   0);
      chk({tag, "_good_cnt"}, ifa.good_cnt, 0);
      chk({tag, "_bad_cnt"},  ifa.bad_cnt,  0);
      chk({tag, "_ovf_err"},  ifa.ovf_err,  0);
      chk({tag, "_unf_err"},  ifa.unf_err,  0);
   endtask

   task automatic do_reset();
      flitEn = 1'b0; dlast = 1'b0; rst_n = 1'b0;
      repeat (3) @(posedge clk);
      #1 rst_n = 1'b1;
   endtask

   // Scoreboard for dut_a: order, values and latency of every result strobe.
   always @(negedge clk) begin
      exp_t e;
      if (rst_n === 1'b1 && ifa.chk_vld === 1'b1) begin
         pulses_a++;
         if (exp_q.size() == 0) begin
            chk("spurious_chk_vld", ifa.chk_vld, 0);
         end else begin
            e = exp_q.pop_front();
            chk("chk_ok",   ifa.chk_ok,   e.ok);
            chk("crc_calc", ifa.crc_calc, e.calc);
            chk("crc_rx",   ifa.crc_rx,   e.rx);
            chk("latency",  cyc,          e.cyc);
         end
      end
   end

   initial begin
      #200000;
      $display("FAIL watchdog: simulation time limit reached before completion");
      $fatal(1);
   end

   initial begin
      logic [DW-1:0] fr[$];
      logic [DW-1:0] f;
      int            p0;
      sel = 0; din = '0; flitEn = 1'b0; dlast = 1'b0; crc_in = '0; rst_n = 1'b1;
      #2 rst_n = 1'b0;
      @(negedge clk);
      check_reset_vals("reset");
      repeat (3) @(posedge clk);
      #1 rst_n = 1'b1;
      idle(2);

      // "123456789" right-aligned in a zero flit, correct CRC.
      f = '0;
      f[71:0] = "123456789";
      fr = {};
      fr.push_back(f);
      send_frame(0, fr, 32'h0);
      drain();
      chk("t1_good_cnt", ifa.good_cnt, 1);
      chk("t1_bad_cnt",  ifa.bad_cnt,  0);
      chk("t1_pulses",   pulses_a,     1);

      // Same frame, received CRC bit 0 flipped.
      send_frame(0, fr, 32'h1);
      drain();
      chk("t2_bad_cnt",   ifa.bad_cnt,  1);
      chk("t2_chk_ok",    ifa.chk_ok,   0);
      chk("t2_rx_vs_calc", ifa.crc_rx ^ ifa.crc_calc, 1);

      // 100 back-to-back single-flit frames, every 5th corrupted.
      do_reset();
      p0 = pulses_a;
      for (int i = 0; i < 100; i++) begin
         fr = {};
         fr.push_back(rand_flit());
         send_frame(0, fr, (i % 5 == 4) ? (32'h1 << $urandom_range(31, 0)) : 32'h0);
      end
      drain();
      chk("t3_pulses",   pulses_a - p0, 100);
      chk("t3_good_cnt", ifa.good_cnt,  80);
      chk("t3_bad_cnt",  ifa.bad_cnt,   20);
      chk("t3_ovf_err",  ifa.ovf_err,   0);
      chk("t3_unf_err",  ifa.unf_err,   0);

      // Reset in the middle of a 4-flit frame; the frame must vanish.
      fr = {};
      for (int i = 0; i < 4; i++) fr.push_back(rand_flit());
      drive_flit(0, fr[0], 1'b0, 32'h0);
      drive_flit(0, fr[1], 1'b0, 32'h0);
      rst_n = 1'b0;
      drive_flit(0, fr[2], 1'b0, 32'h0);
      drive_flit(0, fr[3], 1'b1, crc32_ref(fr));
      flitEn = 1'b0; dlast = 1'b0;
      @(negedge clk);
      check_reset_vals("midrst");
      @(posedge clk);
      #1 rst_n = 1'b1;
      p0 = pulses_a;
      idle(12);
      chk("midrst_no_vld", pulses_a - p0, 0);
      fr = {};
      for (int i = 0; i < 4; i++) fr.push_back(rand_flit());
      send_frame(0, fr, 32'h0);
      drain();
      chk("midrst_next_pulses", pulses_a - p0, 1);
      chk("midrst_next_good",   ifa.good_cnt,  1);

      // DEPTH=2, PIPE_LVL=4: third outstanding push overflows.
      for (int i = 0; i < 8; i++) begin
         fr = {};
         fr.push_back(rand_flit());
         send_frame(1, fr, 32'h0);
         if (i < 3) chk($sformatf("ovf_after_push%0d", i + 1), ifb.ovf_err, (i == 2) ? 1 : 0);
      end
      idle(10);
      chk("ovf_sticky",       ifb.ovf_err, 1);
      // Two pushes were dropped, so the last two results find the FIFO empty.
      chk("unf_after_ovf",    ifb.unf_err, 1);
      chk("ovf_result_count", ifb.good_cnt + ifb.bad_cnt, 6);

      // CNT_W=4: good_cnt saturates at 15.
      for (int i = 0; i < 15; i++) begin
         fr = {};
         fr.push_back(rand_flit());
         send_frame(2, fr, 32'h0);
      end
      idle(8);
      chk("sat_good_15", ifc.good_cnt, 15);
      for (int i = 0; i < 5; i++) begin
         fr = {};
         fr.push_back(rand_flit());
         send_frame(2, fr, 32'h0);
      end
      idle(8);
      chk("sat_good_hold", ifc.good_cnt, 15);
      chk("sat_bad",       ifc.bad_cnt,  0);

      chk("scoreboard_empty", exp_q.size(), 0);
      $display("%0d/%0d checks passed", n_pass, n_chk);
      $finish;
   end

endmodule

// File: doc/crc_check.md
# crc_check

Receive-side CRC checker; the counterpart of the CRC generator. It streams frame flits through a `crc_gen` instance and captures the received CRC from a sideband, one per frame. Each received CRC waits in a small in-order FIFO until `crc_gen` produces the computed value. It then reports pass/fail per frame and keeps good/bad frame statistics. It sits between the link deserializer and frame consumer logic.

## Interface
- `DWIDTH`, 512: flit data width, bits.
- `CRC_WIDTH`, 32: CRC width, bits.
- `PIPE_LVL`, 2: pipeline levels passed to `crc_gen`.
- `CRC_POLY`, `INIT`, `XOR_OUT`, `REFIN`, `REFOUT`: CRC definition, passed unchanged to `crc_gen`. Values must match the transmitter.
- `DEPTH`, 8: received-CRC FIFO depth. Power of two, ≥ 2.
- `CNT_W`, 32: statistics counter width.

Ports:
- `clk`  in  1  single clock.
- `rst_n`  in  1  asynchronous, active-low reset.
- `din`  in  DWIDTH  flit data.
- `flitEn`  in  1  `din` valid this cycle.
- `dlast`  in  1  last flit of frame; qualified by `flitEn`.
- `crc_in`  in  CRC_WIDTH  received CRC; sampled only when `flitEn && dlast`.
- `chk_vld`  out  1  one-cycle result strobe.
- `chk_ok`  out  1  computed CRC equals received CRC; meaningful when `chk_vld`.
- `crc_calc`  out  CRC_WIDTH  computed CRC of the reported frame.
- `crc_rx`  out  CRC_WIDTH  received CRC of the reported frame.
- `good_cnt`, `bad_cnt`  out  CNT_W  saturating frame counters.
- `ovf_err`  out  1  sticky: FIFO overflow (a received CRC was dropped).
- `unf_err`  out  1  sticky: `crc_gen` result arrived with the FIFO empty.

## Operation
- `din`, `flitEn` and `dlast` feed `crc_gen` directly, with no registering in this block.
- `crc_gen.rst` is driven by `!rst_n`. `rst_n` must stay low for ≥ 2 `clk` edges so `crc_gen` clears.
- Push: on `flitEn && dlast`, `crc_in` is written to the FIFO tail.
- Pop: on `crc_gen.crc_out_vld`, the head is read and compared with `crc_gen.crc_out`.
  - The comparison result and both CRC values are registered to the outputs, and `chk_vld` is pulsed.
  - Match: `chk_ok`=1 and `good_cnt` increments. Mismatch: `chk_ok`=0 and `bad_cnt` increments.
  - Both counters saturate at all-ones and do not wrap.
- FIFO: pointers are log2(DEPTH)+1 bits wide, so full/empty are distinguished by the MSB.
- Boundary cases:
  - Push and pop in the same cycle: both happen. When full, the pop frees the slot and the push succeeds.
  - Push when full with no pop: `crc_in` is dropped and `ovf_err` is set. A later mis-paired compare is permitted after overflow.
  - Pop when empty with no push: no `chk_vld`; `unf_err` is set and the counters are unchanged.
  - Pop when empty with a push in the same cycle: the pushed value bypasses the FIFO and is compared directly; `unf_err` stays 0.
- Sticky errors clear only on reset.
- Single-flit frames: one flit with `flitEn && dlast` both high is a complete frame.

## Timing
- Reset (async assert, sync release):
  - `chk_vld`, `chk_ok`, `ovf_err`, `unf_err` = 0.
  - `crc_calc`, `crc_rx` = 0; `good_cnt`, `bad_cnt` = 0.
  - FIFO empty.
- Latency: `chk_vld` rises exactly 1 cycle after `crc_gen.crc_out_vld`. End-to-end, that is `crc_gen` latency + 1 after the `dlast` flit.
- Throughput: one frame result per cycle sustained.
- FIFO occupancy never exceeds the `crc_gen` latency in frames, so `DEPTH` ≥ `PIPE_LVL`+2 guarantees no overflow.
- Reset asserted mid-frame: all in-flight frames are discarded and no `chk_vld` is produced for them.

## Structure
- The shared package `crc_pkg` holds the `crc_result_t` struct (ok, calc, rx) and the `clog2`-based pointer-width constant helper.
- One sub-module: the existing `crc_gen`, instantiated unchanged.
- The FIFO and compare logic are inline, about 150 lines.

## Test plan
- Single 1-flit frame, standard CRC-32 (`REFIN`=`REFOUT`=1, `INIT`=`XOR_OUT`=FFFFFFFF):
  - `din` = "123456789" right-aligned in zeros, `crc_in` = the value from a software model.
  - Required: `chk_vld` once, `chk_ok`=1, `good_cnt`=1.
- Same frame with `crc_in` bit 0 flipped:
  - Required: `chk_ok`=0, `bad_cnt`=1.
  - Required: `crc_rx` and `crc_calc` differ only in bit 0.
- Back-to-back 1-flit frames, 100 of them, every 5th with a corrupted CRC:
  - Required: 100 `chk_vld` pulses in order, `good_cnt`=80, `bad_cnt`=20, `ovf_err`=0.
- `DEPTH`=2, `PIPE_LVL`=4, continuous 1-flit frames:
  - Required: `ovf_err` sets on the 3rd outstanding push and stays set.
- Reset pulsed (`rst_n` low 3 cycles) while a 4-flit frame is mid-stream:
  - Required: all outputs at reset values, no `chk_vld` for that frame.
  - Required: the next clean frame reports `chk_ok`=1.
- Counters with `CNT_W`=4, 20 good frames:
  - Required: `good_cnt` saturates at 15 and holds.
